font_ram_loader: RTL and testbench

//  Writer side of the overlay font/icon store: parses a byte stream from the UDP receive path and

---
 rtl/font_ram_loader_pkg.sv | 33 +++
 rtl/font_ram_loader_if.sv | 25 ++
 rtl/font_ram_loader_px_pack.sv | 69 ++++++
 rtl/font_ram_loader.sv | 185 ++++++++++++++++++
 tb/tb_font_ram_loader.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/font_ram_loader_pkg.sv
// Shared constants for the overlay font store: bitmap geometry, bank ids, packet magic and
// loader state encodings. Also imported by the overlay reader for address range and bank mapping.
package font_ram_loader_pkg;

   localparam int PIX_NUM = 2500;
   localparam int BANKS   = 4;
   localparam int BANK_W  = 2;
   localparam int ADDR_W  = 12;
   localparam int PIX_W   = 24;

   localparam logic [7:0] MAGIC = 8'hA5;

   localparam logic [BANK_W-1:0] BANK_RED   = 2'd0;
   localparam logic [BANK_W-1:0] BANK_GREEN = 2'd1;
   localparam logic [BANK_W-1:0] BANK_BLUE  = 2'd2;
   localparam logic [BANK_W-1:0] BANK_BLACK = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(PIX_NUM - 1);
   localparam logic [7:0]        BANK_LIMIT = 8'(BANKS);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BANK  = 3'd1,
      ST_PIXEL = 3'd2,
      ST_CKSUM = 3'd3,
      ST_DRAIN = 3'd4
   } load_state_e;

   function automatic logic bank_id_ok(input logic [7:0] id);
      return id < BANK_LIMIT;
   endfunction

endpackage

// File: rtl/font_ram_loader_if.sv
// Byte stream from the UDP receive path plus the font RAM write port.
// The loader sits on the slave side: it consumes rx_* and drives wr_*.
interface font_ram_loader_if;
   import font_ram_loader_pkg::*;

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_sop;
   logic              rx_eop;
   logic              wr_en;
   logic [BANK_W-1:0] wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;

   modport master (
      output rx_valid, rx_data, rx_sop, rx_eop,
      input  wr_en, wr_bank, wr_addr, wr_data
   );

   modport slave (
      input  rx_valid, rx_data, rx_sop, rx_eop,
      output wr_en, wr_bank, wr_addr, wr_data
   );

endinterface

// File: rtl/font_ram_loader_px_pack.sv
// Packs R,G,B payload bytes into one 24-bit pixel; pix_vld_o is a registered one-cycle pulse
// the cycle after the B byte. clr_i realigns the phase at the start of a bitmap.
module font_ram_loader_px_pack
   import font_ram_loader_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             byte_vld_i,
   input  logic [7:0]       byte_i,
   output logic             last_byte_o,
   output logic             pix_vld_o,
   output logic [PIX_W-1:0] pix_data_o
);

   logic [1:0]       phase_q, phase_d;
   logic [7:0]       r_q, r_d;
   logic [7:0]       g_q, g_d;
   logic             pix_vld_q, pix_vld_d;
   logic [PIX_W-1:0] pix_data_q, pix_data_d;

   assign last_byte_o = byte_vld_i & ~clr_i & (phase_q == 2'd2);
   assign pix_vld_o   = pix_vld_q;
   assign pix_data_o  = pix_data_q;

   always_comb begin
      phase_d    = phase_q;
      r_d        = r_q;
      g_d        = g_q;
      pix_vld_d  = 1'b0;
      pix_data_d = pix_data_q;
      if (clr_i) begin
         phase_d = 2'd0;
      end else if (byte_vld_i) begin
         case (phase_q)
            2'd0: begin
               r_d     = byte_i;
               phase_d = 2'd1;
            end
            2'd1: begin
               g_d     = byte_i;
               phase_d = 2'd2;
            end
            default: begin
               pix_data_d = {r_q, g_q, byte_i};
               pix_vld_d  = 1'b1;
               phase_d    = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= 2'd0;
         r_q        <= '0;
         g_q        <= '0;
         pix_vld_q  <= 1'b0;
         pix_data_q <= '0;
      end else begin
         phase_q    <= phase_d;
         r_q        <= r_d;
         g_q        <= g_d;
         pix_vld_q  <= pix_vld_d;
         pix_data_q <= pix_data_d;
      end
   end

endmodule

// File: rtl/font_ram_loader.sv
// Writer side of the overlay font store: parses load packets and writes 50x50 RGB888 bitmaps
// into one of four banks. Optional trailing XOR checksum byte enabled by FONT_LOAD_CKSUM_EN.
//
// state    | meaning
// IDLE     | waiting for sop carrying MAGIC; other bytes ignored
// BANK     | header accepted, next byte is the bank id
// PIXEL    | receiving R,G,B triplets, one RAM write per pixel
// CKSUM    | all pixels written, expecting the checksum byte with eop
// DRAIN    | packet rejected, discarding bytes until eop
module font_ram_loader
   import font_ram_loader_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   font_ram_loader_if.slave bus,
   output logic             busy,
   output logic             load_done,
   output logic             load_err,
   output logic [BANKS-1:0] bank_valid
);

   load_state_e       state_q, state_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        cksum_q, cksum_d;
   logic [BANKS-1:0]  bank_valid_q, bank_valid_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              data_byte;
   logic              pk_clr;
   logic              pk_vld;
   logic              pk_last;
   logic              pix_vld;
   logic [PIX_W-1:0]  pix_data;

   assign data_byte = bus.rx_valid & ~bus.rx_sop;
   assign pk_vld    = data_byte & (state_q == ST_PIXEL);
   assign pk_clr    = data_byte & (state_q == ST_BANK) & ~bus.rx_eop & bank_id_ok(bus.rx_data);

   font_ram_loader_px_pack u_px_pack (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (pk_clr),
      .byte_vld_i  (pk_vld),
      .byte_i      (bus.rx_data),
      .last_byte_o (pk_last),
      .pix_vld_o   (pix_vld),
      .pix_data_o  (pix_data)
   );

   always_comb begin
      state_d      = state_q;
      bank_d       = bank_q;
      pix_cnt_d    = pix_cnt_q;
      wr_addr_d    = wr_addr_q;
      cksum_d      = cksum_q;
      bank_valid_d = bank_valid_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      if (bus.rx_valid) begin
         if (bus.rx_sop) begin
            // sop always restarts parsing; anything in flight is abandoned as an error
            err_d = (state_q != ST_IDLE);
            if (bus.rx_eop) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (bus.rx_data == MAGIC) begin
               cksum_d = MAGIC;
               state_d = ST_BANK;
            end else begin
               err_d   = 1'b1;
               state_d = ST_DRAIN;
            end
         end else begin
            cksum_d = cksum_q ^ bus.rx_data;
            case (state_q)
               ST_BANK: begin
                  if (bus.rx_eop) begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else if (pk_clr) begin
                     // reader must blank this bank until the new bitmap is complete
                     bank_d                                   = bus.rx_data[BANK_W-1:0];
                     bank_valid_d[bus.rx_data[BANK_W-1:0]] = 1'b0;
                     pix_cnt_d                                = '0;
                     state_d                                  = ST_PIXEL;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_DRAIN;
                  end
               end
               ST_PIXEL: begin
                  if (pk_last) begin
                     wr_addr_d = pix_cnt_q;
                     if (pix_cnt_q == LAST_PIX) begin
`ifdef FONT_LOAD_CKSUM_EN
                        if (bus.rx_eop) begin
                           err_d   = 1'b1;
                           state_d = ST_IDLE;
                        end else begin
                           state_d = ST_CKSUM;
                        end
`else
                        if (bus.rx_eop) begin
                           done_d               = 1'b1;
                           bank_valid_d[bank_q] = 1'b1;
                           state_d              = ST_IDLE;
                        end else begin
                           err_d   = 1'b1;
                           state_d = ST_DRAIN;
                        end
`endif
                     end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (bus.rx_eop) begin
                           err_d   = 1'b1;
                           state_d = ST_IDLE;
                        end
                     end
                  end else if (bus.rx_eop) begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
               ST_CKSUM: begin
                  if (!bus.rx_eop) begin
                     err_d   = 1'b1;
                     state_d = ST_DRAIN;
                  end else if (cksum_q == bus.rx_data) begin
                     done_d               = 1'b1;
                     bank_valid_d[bank_q] = 1'b1;
                     state_d              = ST_IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
               ST_DRAIN: begin
                  if (bus.rx_eop) begin
                     state_d = ST_IDLE;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         bank_q       <= '0;
         pix_cnt_q    <= '0;
         wr_addr_q    <= '0;
         cksum_q      <= '0;
         bank_valid_q <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bank_q       <= bank_d;
         pix_cnt_q    <= pix_cnt_d;
         wr_addr_q    <= wr_addr_d;
         cksum_q      <= cksum_d;
         bank_valid_q <= bank_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign load_done   = done_q;
   assign load_err    = err_q;
   assign bank_valid  = bank_valid_q;

   assign bus.wr_en   = pix_vld;
   assign bus.wr_bank = bank_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = pix_data;

endmodule

// File: tb/tb_font_ram_loader.sv
// Scoreboard bench for font_ram_loader: a packet-level model predicts writes and done/err
// events into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_font_ram_loader;
   import font_ram_loader_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             busy, load_done, load_err;
   logic [BANKS-1:0] bank_valid;

   font_ram_loader_if bus ();

   font_ram_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .busy       (busy),
      .load_done  (load_done),
      .load_err   (load_err),
      .bank_valid (bank_valid)
   );

   always #5 clk = ~clk;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [37:0]      exp_wr[$];
   logic [1:0]       exp_ev[$];
   logic [7:0]       pkt[$];
   logic [BANKS-1:0] model_valid;
   bit               gap_en;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every write and every done/err pulse must match the head of its queue
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL write: unexpected write bank %0d addr %0d, none expected",
                        bus.wr_bank, bus.wr_addr);
            end else begin
               check("write", {bus.wr_bank, bus.wr_addr, bus.wr_data}, exp_wr.pop_front());
            end
         end
         if (load_done === 1'b1 || load_err === 1'b1) begin
            if (exp_ev.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL event: unexpected done=%0b err=%0b, none expected",
                        load_done, load_err);
            end else begin
               check("event_err_done", {load_err, load_done}, exp_ev.pop_front());
            end
         end
      end
   end

   task automatic push_write(input int b, input int a, input logic [23:0] d);
      exp_wr.push_back({b[1:0], a[ADDR_W-1:0], d});
   endtask

   // Packet-level outcome: term = packet ends with eop (otherwise a later sop cuts it short)
   task automatic model_packet(input bit term);
      int         n;
      int         b;
      int         body;
      int         nw;
      int         need;
      bit         ok;
      logic [7:0] x;
      n = pkt.size();
      if (n < 2 || pkt[0] != MAGIC || (term && n == 2) || pkt[1] >= BANKS) begin
         exp_ev.push_back(2'b10);
         return;
      end
      b = int'(pkt[1]);
      model_valid[b] = 1'b0;
      body = n - 2;
      nw = body / 3;
      if (nw > PIX_NUM) nw = PIX_NUM;
      for (int i = 0; i < nw; i++)
         push_write(b, i, {pkt[2 + 3*i], pkt[3 + 3*i], pkt[4 + 3*i]});
      need = 3 * PIX_NUM;
`ifdef FONT_LOAD_CKSUM_EN
      need = need + 1;
`endif
      ok = term && (body == need);
`ifdef FONT_LOAD_CKSUM_EN
      x = 8'h00;
      for (int i = 0; i < n - 1; i++) x = x ^ pkt[i];
      if (x != pkt[n-1]) ok = 1'b0;
`endif
      if (ok) begin
         exp_ev.push_back(2'b01);
         model_valid[b] = 1'b1;
      end else begin
         exp_ev.push_back(2'b10);
      end
   endtask

   task automatic build_hdr(input logic [7:0] m, input logic [7:0] id);
      pkt.delete();
      pkt.push_back(m);
      pkt.push_back(id);
   endtask

   task automatic add_pixels(input int n, input bit pattern);
      logic [23:0] d;
      for (int i = 0; i < n; i++) begin
         if (pattern) d = {i[7:0], ~i[7:0], 8'h55};
         else         d = 24'($urandom);
         pkt.push_back(d[23:16]);
         pkt.push_back(d[15:8]);
         pkt.push_back(d[7:0]);
      end
   endtask

   task automatic add_random(input int n);
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
   endtask

   task automatic add_cksum();
      logic [7:0] x;
      x = 8'h00;
      foreach (pkt[i]) x = x ^ pkt[i];
      pkt.push_back(x);
   endtask

   task automatic finish_full();
`ifdef FONT_LOAD_CKSUM_EN
      add_cksum();
`endif
   endtask

   task automatic send_byte(input logic [7:0] d, input bit sop, input bit eop);
      if (gap_en) repeat ($urandom_range(0, 2)) begin
         @(posedge clk);
         #1;
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = d;
      bus.rx_sop   = sop;
      bus.rx_eop   = eop;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_sop   = 1'b0;
      bus.rx_eop   = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic send_bytes(input int lo, input int hi, input bit term);
      for (int i = lo; i < hi; i++)
         send_byte(pkt[i], i == 0, term && (i == pkt.size() - 1));
   endtask

   task automatic send_pkt(input bit term);
      model_packet(term);
      send_bytes(0, pkt.size(), term);
   endtask

   task automatic settle(input string tag);
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_writes_drained"}, exp_wr.size(), 0);
      check({tag, "_events_drained"}, exp_ev.size(), 0);
      check({tag, "_bank_valid"}, bank_valid, model_valid);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached before end of stimulus");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_sop   = 1'b0;
      bus.rx_eop   = 1'b0;
      gap_en       = 1'b0;
      model_valid  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", load_done, 0);
      check("reset_err", load_err, 0);
      check("reset_wr_en", bus.wr_en, 0);
      check("reset_wr_addr", bus.wr_addr, 0);
      check("reset_bank_valid", bank_valid, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // good load, bank 2, index pattern
      build_hdr(MAGIC, 8'd2);
      add_pixels(PIX_NUM, 1'b1);
      finish_full();
      send_pkt(1'b1);
      settle("good_b2");
      check("good_b2_valid_vec", bank_valid, 4'b0100);

      // wrong magic
      build_hdr(8'h5A, 8'd2);
      add_random(9);
      send_pkt(1'b1);
      settle("bad_magic");

      // sop and eop on the magic byte
      pkt.delete();
      pkt.push_back(MAGIC);
      send_pkt(1'b1);
      settle("sop_eop");

      // bad bank id, long drain
      build_hdr(MAGIC, 8'd7);
      add_random(7500);
      model_packet(1'b1);
      send_bytes(0, pkt.size() - 1, 1'b1);
      check("drain_busy", busy, 1);
      send_bytes(pkt.size() - 1, pkt.size(), 1'b1);
      settle("bad_id");
      check("drain_idle", busy, 0);

      // bank 1 valid, then short reload ending on pixel 1000
      build_hdr(MAGIC, 8'd1);
      add_pixels(PIX_NUM, 1'b0);
      finish_full();
      send_pkt(1'b1);
      settle("good_b1");
      build_hdr(MAGIC, 8'd1);
      add_pixels(1001, 1'b0);
      send_pkt(1'b1);
      settle("short_b1");

      // eop on a G byte
      build_hdr(MAGIC, 8'd1);
      add_pixels(5, 1'b0);
      add_random(2);
      send_pkt(1'b1);
      settle("mid_pixel");

      // sop arrives mid bank 0 load, then full bank 3 load
      build_hdr(MAGIC, 8'd0);
      add_pixels(600, 1'b0);
      add_random(1);
      send_pkt(1'b0);
      build_hdr(MAGIC, 8'd3);
      add_pixels(PIX_NUM, 1'b0);
      finish_full();
      send_pkt(1'b1);
      settle("abort_then_b3");

      // long packet
      build_hdr(MAGIC, 8'd3);
      add_pixels(PIX_NUM, 1'b0);
      add_random(3);
      send_pkt(1'b1);
      settle("long_b3");

      // good bank 2 reload with random rx_valid gaps
      gap_en = 1'b1;
      build_hdr(MAGIC, 8'd2);
      add_pixels(PIX_NUM, 1'b1);
      finish_full();
      model_packet(1'b1);
      send_bytes(0, 1000, 1'b1);
      check("gaps_valid_cleared", bank_valid[2], 0);
      send_bytes(1000, pkt.size(), 1'b1);
      gap_en = 1'b0;
      settle("gaps_b2");

`ifdef FONT_LOAD_CKSUM_EN
      build_hdr(MAGIC, 8'd0);
      add_pixels(PIX_NUM, 1'b0);
      add_cksum();
      pkt[pkt.size()-1] = pkt[pkt.size()-1] ^ 8'h10;
      send_pkt(1'b1);
      settle("cksum_bad");
`endif

      // reset in the middle of a load
      build_hdr(MAGIC, 8'd2);
      add_pixels(300, 1'b0);
      model_packet(1'b0);
      send_bytes(0, pkt.size(), 1'b0);
      rst_n = 1'b0;
      #1;
      check("midreset_wr_en", bus.wr_en, 0);
      check("midreset_bank_valid", bank_valid, 0);
      check("midreset_busy", busy, 0);
      exp_wr.delete();
      exp_ev.delete();
      model_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
